// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Desc     : MEM pipeline stage: dTLB/supervisor address translation, data-cache
//            request/response handshake, load/store byte alignment, WB registers.
//            Optional macro MEM_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5,
    parameter int PPN_W = 20,
    parameter int OFF_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              supervisor_mode_i,
    input  logic              ex_valid_i,
    input  logic              ex_mem_rd_i,
    input  logic              ex_mem_wr_i,
    input  logic [1:0]        ex_size_i,
    input  logic              ex_unsigned_i,
    input  logic              ex_wb_en_i,
    input  logic [REG_W-1:0]  ex_rd_i,
    input  logic [XLEN-1:0]   ex_addr_i,
    input  logic [XLEN-1:0]   ex_wdata_i,
    input  logic [XLEN-1:0]   ex_pc_i,
    input  logic              ex_tlb_miss_i,
    input  logic              tlb_hit_i,
    input  logic [PPN_W-1:0]  tlb_ppn_i,
    output logic              stall_o,
    output logic              dc_req_valid_o,
    output logic              dc_req_we_o,
    output logic [XLEN-1:0]   dc_req_addr_o,
    output logic [XLEN-1:0]   dc_req_wdata_o,
    output logic [XLEN/8-1:0] dc_req_be_o,
    input  logic              dc_req_ready_i,
    input  logic              dc_rsp_valid_i,
    input  logic [XLEN-1:0]   dc_rsp_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_wb_en_o,
    output logic              wb_mem_to_reg_o,
    output logic [REG_W-1:0]  wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              wb_exc_o,
    output logic [1:0]        wb_cause_o,
    output logic [XLEN-1:0]   wb_badaddr_o,
    output logic [XLEN-1:0]   wb_pc_o
);
    localparam int BL = XLEN / 8;
    localparam int OW = $clog2(BL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   kill_q, kill_d;
    logic   cap_en_w;

    // Captured access, held stable while the cache request is outstanding
    logic              we_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              wb_en_q;
    logic [REG_W-1:0]  rd_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   vaddr_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [BL-1:0]     be_q;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_wb_en_q, wb_wb_en_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              wb_exc_q, wb_exc_d;
    logic [1:0]        wb_cause_q, wb_cause_d;
    logic [XLEN-1:0]   wb_badaddr_q, wb_badaddr_d;
    logic [XLEN-1:0]   wb_pc_q, wb_pc_d;

    logic [XLEN-1:0]   paddr_w;
    logic [3:0]        nbytes_w;
    logic [XLEN-1:0]   size_mask_w;
    logic [XLEN-1:0]   req_addr_w;
    logic [OW-1:0]     off_w;
    logic [BL-1:0]     be_w;
    logic [XLEN-1:0]   wdata_rep_w;
    logic              mem_op_w;
    logic              dtlb_miss_w;
    logic [1:0]        cause_w;
    logic              exc_w;

    always_comb begin
        paddr_w = '0;
        if (supervisor_mode_i) begin
            paddr_w = ex_addr_i;
        end else begin
            paddr_w[PPN_W+OFF_W-1:0] = {tlb_ppn_i, ex_addr_i[OFF_W-1:0]};
        end
    end

    assign nbytes_w    = 4'd1 << ex_size_i;
    assign size_mask_w = {{(XLEN-4){1'b0}}, nbytes_w - 4'd1};
    // Accesses are always issued size-aligned; with trapping enabled this is a no-op
    assign req_addr_w  = paddr_w & ~size_mask_w;
    assign off_w       = req_addr_w[OW-1:0];

    always_comb begin
        be_w        = '0;
        wdata_rep_w = '0;
        for (int i = 0; i < BL; i++) begin
            if ((i >= int'(off_w)) && (i < int'(off_w) + int'(nbytes_w))) begin
                be_w[i] = 1'b1;
            end
            wdata_rep_w[8*i +: 8] = ex_wdata_i[8*(i & (int'(nbytes_w) - 1)) +: 8];
        end
    end

    assign mem_op_w    = ex_mem_rd_i | ex_mem_wr_i;
    assign dtlb_miss_w = mem_op_w & ~supervisor_mode_i & ~tlb_hit_i;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_w;
    assign misalign_w = mem_op_w & (|(ex_addr_i & size_mask_w));
`endif

    always_comb begin
        cause_w = 2'd0;
        if (ex_tlb_miss_i) begin
            cause_w = 2'd2;
        end else if (dtlb_miss_w) begin
            cause_w = 2'd1;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        else if (misalign_w) begin
            cause_w = 2'd3;
        end
`endif
    end
    assign exc_w = |cause_w;

    logic [XLEN-1:0] rdata_sh_w;
    logic [XLEN-1:0] ext_mask_w;
    logic            sign_w;
    logic [XLEN-1:0] load_ext_w;

    assign rdata_sh_w = dc_rsp_rdata_i >> {addr_q[OW-1:0], 3'b000};

    always_comb begin
        ext_mask_w = '1;
        sign_w     = 1'b0;
        case (size_q)
            2'd0: begin ext_mask_w = XLEN'(8'hFF);         sign_w = rdata_sh_w[7];  end
            2'd1: begin ext_mask_w = XLEN'(16'hFFFF);      sign_w = rdata_sh_w[15]; end
            2'd2: begin ext_mask_w = XLEN'(32'hFFFF_FFFF); sign_w = rdata_sh_w[31]; end
            default: ;
        endcase
        load_ext_w = (rdata_sh_w & ext_mask_w) | (~ext_mask_w & {XLEN{sign_w & ~unsigned_q}});
    end

    always_comb begin
        state_d         = state_q;
        kill_d          = kill_q;
        cap_en_w        = 1'b0;
        stall_o         = 1'b0;
        dc_req_valid_o  = 1'b0;
        wb_valid_d      = 1'b0;
        wb_wb_en_d      = wb_wb_en_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        wb_exc_d        = wb_exc_q;
        wb_cause_d      = wb_cause_q;
        wb_badaddr_d    = wb_badaddr_q;
        wb_pc_d         = wb_pc_q;

        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (ex_valid_i && !flush_i) begin
                    if (exc_w) begin
                        wb_valid_d      = 1'b1;
                        wb_wb_en_d      = 1'b0;
                        wb_mem_to_reg_d = 1'b0;
                        wb_rd_d         = ex_rd_i;
                        wb_data_d       = ex_addr_i;
                        wb_exc_d        = 1'b1;
                        wb_cause_d      = cause_w;
                        wb_badaddr_d    = ex_addr_i;
                        wb_pc_d         = ex_pc_i;
                    end else if (mem_op_w) begin
                        cap_en_w = 1'b1;
                        stall_o  = 1'b1;
                        state_d  = S_REQ;
                    end else begin
                        wb_valid_d      = 1'b1;
                        wb_wb_en_d      = ex_wb_en_i;
                        wb_mem_to_reg_d = 1'b0;
                        wb_rd_d         = ex_rd_i;
                        wb_data_d       = ex_addr_i;
                        wb_exc_d        = 1'b0;
                        wb_cause_d      = 2'd0;
                        wb_badaddr_d    = '0;
                        wb_pc_d         = ex_pc_i;
                    end
                end
            end
            S_REQ: begin
                dc_req_valid_o = 1'b1;
                if (dc_req_ready_i) begin
                    if (we_q) begin
                        state_d = S_IDLE;
                        if (!flush_i) begin
                            wb_valid_d      = 1'b1;
                            wb_wb_en_d      = wb_en_q;
                            wb_mem_to_reg_d = 1'b0;
                            wb_rd_d         = rd_q;
                            wb_data_d       = vaddr_q;
                            wb_exc_d        = 1'b0;
                            wb_cause_d      = 2'd0;
                            wb_badaddr_d    = '0;
                            wb_pc_d         = pc_q;
                        end
                    end else begin
                        // Accepted load: a flush now only suppresses its writeback
                        state_d = S_WAIT;
                        stall_o = 1'b1;
                        kill_d  = flush_i;
                    end
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            S_WAIT: begin
                if (dc_rsp_valid_i) begin
                    state_d = S_IDLE;
                    if (!(kill_q || flush_i)) begin
                        wb_valid_d      = 1'b1;
                        wb_wb_en_d      = wb_en_q;
                        wb_mem_to_reg_d = 1'b1;
                        wb_rd_d         = rd_q;
                        wb_data_d       = load_ext_w;
                        wb_exc_d        = 1'b0;
                        wb_cause_d      = 2'd0;
                        wb_badaddr_d    = '0;
                        wb_pc_d         = pc_q;
                    end
                end else begin
                    stall_o = 1'b1;
                    if (flush_i) begin
                        kill_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            kill_q          <= 1'b0;
            we_q            <= 1'b0;
            size_q          <= 2'd0;
            unsigned_q      <= 1'b0;
            wb_en_q         <= 1'b0;
            rd_q            <= '0;
            pc_q            <= '0;
            vaddr_q         <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            be_q            <= '0;
            wb_valid_q      <= 1'b0;
            wb_wb_en_q      <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            wb_exc_q        <= 1'b0;
            wb_cause_q      <= 2'd0;
            wb_badaddr_q    <= '0;
            wb_pc_q         <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (cap_en_w) begin
                we_q       <= ex_mem_wr_i;
                size_q     <= ex_size_i;
                unsigned_q <= ex_unsigned_i;
                wb_en_q    <= ex_wb_en_i;
                rd_q       <= ex_rd_i;
                pc_q       <= ex_pc_i;
                vaddr_q    <= ex_addr_i;
                addr_q     <= req_addr_w;
                wdata_q    <= wdata_rep_w;
                be_q       <= be_w;
            end
            wb_valid_q      <= wb_valid_d;
            wb_wb_en_q      <= wb_wb_en_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            wb_exc_q        <= wb_exc_d;
            wb_cause_q      <= wb_cause_d;
            wb_badaddr_q    <= wb_badaddr_d;
            wb_pc_q         <= wb_pc_d;
        end
    end

    assign dc_req_we_o     = we_q;
    assign dc_req_addr_o   = addr_q;
    assign dc_req_wdata_o  = wdata_q;
    assign dc_req_be_o     = be_q;
    assign wb_valid_o      = wb_valid_q;
    assign wb_wb_en_o      = wb_wb_en_q;
    assign wb_mem_to_reg_o = wb_mem_to_reg_q;
    assign wb_rd_o         = wb_rd_q;
    assign wb_data_o       = wb_data_q;
    assign wb_exc_o        = wb_exc_q;
    assign wb_cause_o      = wb_cause_q;
    assign wb_badaddr_o    = wb_badaddr_q;
    assign wb_pc_o         = wb_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Desc     : Self-checking bench for mem_stage_lsu (default build) with a
//            byte-array cache model and directed plus random instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        supervisor_mode_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_mem_rd_i = 1'b0;
    logic        ex_mem_wr_i = 1'b0;
    logic [1:0]  ex_size_i = 2'd0;
    logic        ex_unsigned_i = 1'b0;
    logic        ex_wb_en_i = 1'b0;
    logic [4:0]  ex_rd_i = 5'd0;
    logic [31:0] ex_addr_i = 32'd0;
    logic [31:0] ex_wdata_i = 32'd0;
    logic [31:0] ex_pc_i = 32'd0;
    logic        ex_tlb_miss_i = 1'b0;
    logic        tlb_hit_i = 1'b1;
    logic [19:0] tlb_ppn_i = 20'd0;
    logic        stall_o;
    logic        dc_req_valid_o;
    logic        dc_req_we_o;
    logic [31:0] dc_req_addr_o;
    logic [31:0] dc_req_wdata_o;
    logic [3:0]  dc_req_be_o;
    logic        dc_req_ready_i = 1'b0;
    logic        dc_rsp_valid_i = 1'b0;
    logic [31:0] dc_rsp_rdata_i = 32'd0;
    logic        wb_valid_o;
    logic        wb_wb_en_o;
    logic        wb_mem_to_reg_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_exc_o;
    logic [1:0]  wb_cause_o;
    logic [31:0] wb_badaddr_o;
    logic [31:0] wb_pc_o;

    always #5 clk_i = ~clk_i;

    mem_stage_lsu #(.XLEN(32), .REG_W(5), .PPN_W(20), .OFF_W(12)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .supervisor_mode_i(supervisor_mode_i), .ex_valid_i(ex_valid_i),
        .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_wr_i(ex_mem_wr_i), .ex_size_i(ex_size_i),
        .ex_unsigned_i(ex_unsigned_i), .ex_wb_en_i(ex_wb_en_i), .ex_rd_i(ex_rd_i),
        .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_pc_i(ex_pc_i),
        .ex_tlb_miss_i(ex_tlb_miss_i), .tlb_hit_i(tlb_hit_i), .tlb_ppn_i(tlb_ppn_i),
        .stall_o(stall_o), .dc_req_valid_o(dc_req_valid_o), .dc_req_we_o(dc_req_we_o),
        .dc_req_addr_o(dc_req_addr_o), .dc_req_wdata_o(dc_req_wdata_o),
        .dc_req_be_o(dc_req_be_o), .dc_req_ready_i(dc_req_ready_i),
        .dc_rsp_valid_i(dc_rsp_valid_i), .dc_rsp_rdata_i(dc_rsp_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_wb_en_o(wb_wb_en_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_exc_o(wb_exc_o),
        .wb_cause_o(wb_cause_o), .wb_badaddr_o(wb_badaddr_o), .wb_pc_o(wb_pc_o)
    );

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] mem [int unsigned];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bubble();
        ex_valid_i  = 1'b0;
        ex_mem_rd_i = 1'b0;
        ex_mem_wr_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_req_valid"}, dc_req_valid_o, 0);
        chk({tag, "_req_we"}, dc_req_we_o, 0);
        chk({tag, "_req_addr"}, dc_req_addr_o, 0);
        chk({tag, "_req_wdata"}, dc_req_wdata_o, 0);
        chk({tag, "_req_be"}, dc_req_be_o, 0);
        chk({tag, "_wb_valid"}, wb_valid_o, 0);
        chk({tag, "_wb_wb_en"}, wb_wb_en_o, 0);
        chk({tag, "_wb_m2r"}, wb_mem_to_reg_o, 0);
        chk({tag, "_wb_rd"}, wb_rd_o, 0);
        chk({tag, "_wb_data"}, wb_data_o, 0);
        chk({tag, "_wb_exc"}, wb_exc_o, 0);
        chk({tag, "_wb_cause"}, wb_cause_o, 0);
        chk({tag, "_wb_badaddr"}, wb_badaddr_o, 0);
        chk({tag, "_wb_pc"}, wb_pc_o, 0);
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store. Called at posedge+1, returns at posedge+1.
    task automatic run_op(input int kind, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic sup, input logic hit, input logic [19:0] ppn,
                          input logic itlb, input int rdy_dly, input int rsp_dly);
        logic [4:0]  rd   = 5'($urandom);
        logic [31:0] pc   = $urandom;
        logic        wben = 1'($urandom);
        logic [31:0] pa, base, exp_wd, exp_ld;
        logic [63:0] v;
        logic [1:0]  cause;
        int          nb, bev;
        logic [3:0]  exp_be;

        nb = 1 << size;
        pa = sup ? addr : {ppn, addr[11:0]};
        pa = pa - (pa % nb);
        base = {pa[31:2], 2'b00};
        cause = itlb ? 2'd2 : ((kind != 0 && !sup && !hit) ? 2'd1 : 2'd0);
        bev = ((1 << nb) - 1) << int'(pa % 4);
        exp_be = bev[3:0];
        case (nb)
            1:       exp_wd = {4{wdata[7:0]}};
            2:       exp_wd = {2{wdata[15:0]}};
            default: exp_wd = wdata;
        endcase
        v = 64'd0;
        for (int k = 0; k < nb; k++) v = v | (64'(mem_rd(pa + k)) << (8 * k));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
        exp_ld = v[31:0];

        ex_valid_i = 1'b1; ex_mem_rd_i = (kind == 1); ex_mem_wr_i = (kind == 2);
        ex_size_i = size; ex_unsigned_i = uns; ex_wb_en_i = wben; ex_rd_i = rd;
        ex_addr_i = addr; ex_wdata_i = wdata; ex_pc_i = pc; ex_tlb_miss_i = itlb;
        supervisor_mode_i = sup; tlb_hit_i = hit; tlb_ppn_i = ppn;
        #1;
        if (cause != 2'd0 || kind == 0) begin
            chk("pass_stall", stall_o, 0);
            chk("pass_req_valid", dc_req_valid_o, 0);
            tick();
            bubble();
            chk("pass_wb_valid", wb_valid_o, 1);
            chk("pass_wb_exc", wb_exc_o, (cause != 2'd0));
            chk("pass_wb_cause", wb_cause_o, cause);
            chk("pass_wb_wb_en", wb_wb_en_o, (cause != 2'd0) ? 1'b0 : wben);
            chk("pass_wb_m2r", wb_mem_to_reg_o, 0);
            chk("pass_wb_rd", wb_rd_o, rd);
            chk("pass_wb_pc", wb_pc_o, pc);
            if (cause != 2'd0) chk("exc_badaddr", wb_badaddr_o, addr);
            else               chk("alu_wb_data", wb_data_o, addr);
        end else begin
            chk("acc_stall", stall_o, 1);
            chk("acc_req_valid", dc_req_valid_o, 0);
            tick();
            for (int k = 0; k <= rdy_dly; k++) begin
                dc_req_ready_i = (k == rdy_dly);
                #1;
                chk("req_valid", dc_req_valid_o, 1);
                chk("req_we", dc_req_we_o, (kind == 2));
                chk("req_addr", dc_req_addr_o, pa);
                chk("req_stall", stall_o, !(kind == 2 && k == rdy_dly));
                chk("req_wb_valid", wb_valid_o, 0);
                if (kind == 2) begin
                    chk("req_be", dc_req_be_o, exp_be);
                    chk("req_wdata", dc_req_wdata_o, exp_wd);
                    if (k == rdy_dly)
                        for (int i = 0; i < 4; i++)
                            if (dc_req_be_o[i]) mem[int'(base) + i] = dc_req_wdata_o[8*i +: 8];
                end
                tick();
            end
            dc_req_ready_i = 1'b0;
            if (kind == 1) begin
                for (int j = 0; j <= rsp_dly; j++) begin
                    dc_rsp_valid_i = (j == rsp_dly);
                    dc_rsp_rdata_i = (j == rsp_dly) ?
                        {mem_rd(base + 3), mem_rd(base + 2), mem_rd(base + 1), mem_rd(base)} : $urandom;
                    #1;
                    chk("wait_stall", stall_o, (j != rsp_dly));
                    chk("wait_req_valid", dc_req_valid_o, 0);
                    chk("wait_wb_valid", wb_valid_o, 0);
                    tick();
                end
                dc_rsp_valid_i = 1'b0;
            end
            bubble();
            chk("mem_wb_valid", wb_valid_o, 1);
            chk("mem_wb_exc", wb_exc_o, 0);
            chk("mem_wb_m2r", wb_mem_to_reg_o, (kind == 1));
            chk("mem_wb_wb_en", wb_wb_en_o, wben);
            chk("mem_wb_rd", wb_rd_o, rd);
            chk("mem_wb_pc", wb_pc_o, pc);
            if (kind == 1) chk("load_data", wb_data_o, exp_ld);
        end
        tick();
        chk("single_pulse", wb_valid_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < 4; p++)
            for (int o = 0; o < 260; o++) mem[p * 4096 + o] = 8'($urandom);
        mem[32'h2004] = 8'hEF; mem[32'h2005] = 8'hBE;
        mem[32'h2006] = 8'hAD; mem[32'h2007] = 8'hDE;

        repeat (2) tick();
        chk_all_zero("reset");
        rst_ni = 1'b1;
        tick();

        // Translated word load, immediate ready and response
        run_op(1, 2'd2, 1'b0, 32'h0000_1004, 32'h0, 1'b0, 1'b1, 20'h00002, 1'b0, 0, 0);
        // Supervisor byte store then signed byte load of the same location
        run_op(2, 2'd0, 1'b0, 32'h0000_0003, 32'h0000_00A5, 1'b1, 1'b1, 20'h0, 1'b0, 0, 0);
        run_op(1, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 1'b1, 1'b1, 20'h0, 1'b0, 0, 0);
        // Slow cache acceptance
        run_op(1, 2'd2, 1'b1, 32'h0000_0010, 32'h0, 1'b1, 1'b1, 20'h0, 1'b0, 4, 2);
        // iTLB miss outranks dTLB miss; then plain dTLB miss
        run_op(1, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 20'h1, 1'b1, 0, 0);
        run_op(1, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 20'h1, 1'b0, 0, 0);
        // Misaligned half load is aligned down in the default build
        run_op(1, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 20'h0, 1'b0, 0, 0);

        // Flush of an incoming instruction in IDLE
        ex_valid_i = 1'b1; ex_mem_rd_i = 1'b0; ex_mem_wr_i = 1'b0; ex_tlb_miss_i = 1'b0;
        flush_i = 1'b1;
        #1;
        chk("flush_idle_stall", stall_o, 0);
        tick();
        bubble();
        chk("flush_idle_wb_valid", wb_valid_o, 0);

        // Flush while the request waits for ready
        ex_valid_i = 1'b1; ex_mem_rd_i = 1'b1; ex_size_i = 2'd2; ex_addr_i = 32'h20;
        supervisor_mode_i = 1'b1;
        #1;
        chk("flreq_acc_stall", stall_o, 1);
        tick();
        flush_i = 1'b1;
        #1;
        chk("flreq_req_valid", dc_req_valid_o, 1);
        chk("flreq_stall", stall_o, 0);
        tick();
        bubble();
        chk("flreq_dropped", dc_req_valid_o, 0);
        chk("flreq_wb_valid", wb_valid_o, 0);
        tick();
        chk("flreq_wb_valid2", wb_valid_o, 0);

        // Reset while waiting for a load response
        ex_valid_i = 1'b1; ex_mem_rd_i = 1'b1; ex_size_i = 2'd2; ex_addr_i = 32'h24;
        #1;
        tick();
        dc_req_ready_i = 1'b1;
        tick();
        dc_req_ready_i = 1'b0;
        #1;
        chk("rstw_wait_stall", stall_o, 1);
        bubble();
        rst_ni = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        tick();
        rst_ni = 1'b1;
        dc_rsp_valid_i = 1'b1; dc_rsp_rdata_i = 32'hCAFE_F00D;
        tick();
        dc_rsp_valid_i = 1'b0;
        chk("rstw_rsp_ignored", wb_valid_o, 0);
        chk("rstw_no_stall", stall_o, 0);

        // Randomised instruction mix
        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic        sup;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            sup  = 1'($urandom_range(0, 1));
            if (sup) begin
                a = $urandom_range(0, 255);
            end else begin
                a = $urandom;
                a[11:0] = 12'($urandom_range(0, 255));
            end
            run_op(kind, 2'($urandom_range(0, 2)), 1'($urandom), a, $urandom, sup,
                   ($urandom_range(0, 9) != 0), 20'($urandom_range(0, 3)),
                   ($urandom_range(0, 19) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
